pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the pipelined MIPS core; replaces the single-cycle PC register.
- Holds the fetch address and selects the next PC from sequential, branch, jump, exception-entry or ERET sources with fixed priority.
- Supports fetch stall and buffers a redirect that arrives while stalled.
- Flags misaligned or out-of-range fetch addresses for the exception unit.

Parameters:
WIDTH, 32, address width in bits
RESET_ADDR, 32'h0000_3000, PC value after reset
EXC_ADDR, 32'h0000_4180, exception handler entry address
IMEM_LO, 32'h0000_3000, lowest legal fetch address
IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
stall_i  in  1  hold PC (hazard stall from decode)
br_taken_i  in  1  branch redirect request
br_target_i  in  WIDTH  branch target
jump_i  in  1  jump redirect request (j/jal/jr)
jump_target_i  in  WIDTH  jump target
exc_req_i  in  1  exception or interrupt taken
eret_i  in  1  return from exception
epc_i  in  WIDTH  return address for eret
pc_o  out  WIDTH  current fetch address
pc4_o  out  WIDTH  pc_o + 4, combinational
adel_o  out  1  fetch address error, combinational
pend_o  out  1  a buffered redirect is pending

Behaviour:
- Reset (sync, active-high, clk): pc_o=RESET_ADDR, pend_o=0, pending target cleared. Reset wins over every other input. Reset mid-PENDING discards the buffered target.
- Redirect priority, highest first: exc_req_i > eret_i > jump_i > br_taken_i > sequential (pc_o+4). "Redirect" = any of the first four is asserted.
- exc_req_i ignores stall_i: next cycle pc_o=EXC_ADDR and the pending buffer is cleared (flush). No other input has effect that cycle.
- FSM states:
  - RUN:
    - stall_i=0: pc_o <= selected target, or pc_o+4 if none.
    - stall_i=1 with a non-exception redirect: pc_o held; target latched into pend_tgt; go to PENDING.
    - stall_i=1 with no redirect: pc_o held.
  - PENDING (pend_o=1):
    - stall_i=1: pc_o held. A new non-exception redirect overwrites pend_tgt only if higher priority than the latched one (eret > jump > branch); the latched kind is stored in a 2-bit field.
    - stall_i=0: pc_o <= pend_tgt; go to RUN. Simultaneous fresh redirect/sequential inputs are ignored that cycle.
    - exc_req_i: pc_o <= EXC_ADDR; go to RUN.
- Latency: a redirect seen at edge N appears on pc_o after edge N; a buffered redirect appears one edge after stall_i falls.
- Arithmetic: pc4_o = pc_o + 4, modulo 2^WIDTH; wrap is not trapped here. Targets are used verbatim, never realigned.
- adel_o = (pc_o[1:0] != 0) | (pc_o < IMEM_LO) | (pc_o > IMEM_HI). Unsigned compare; purely combinational on pc_o. The PC still advances; the exception unit decides.
- No X on outputs after the first reset edge. Before any reset, pc_o initialises to RESET_ADDR.

Decomposition:
- Shared package cpu_pkg:
  - WIDTH default
  - RESET_ADDR, EXC_ADDR, IMEM_LO, IMEM_HI
  - redirect-kind encoding: NONE=0, BR=1, JMP=2, ERET=3
  - FSM state encoding: RUN, PENDING
- One natural sub-module, pc_next_sel: combinational priority mux producing target and kind. The FSM and registers stay in pc_unit.

Test Plan:
- Reset then 3 free-running cycles -> pc_o 0x3000, 0x3004, 0x3008, 0x300C; adel_o=0 throughout.
- At pc 0x3010: br_taken_i=1, br_target_i=0x3100, and jump_i=1, jump_target_i=0x3200 in the same cycle -> next pc_o=0x3200.
- stall_i=1 for 2 cycles, br_taken_i=1 target 0x3400 in the first stalled cycle -> pc_o held, pend_o=1. After stall_i falls -> pc_o=0x3400, pend_o=0.
- In PENDING (branch 0x3400 latched, stall_i=1), assert exc_req_i -> next pc_o=0x4180, pend_o=0; after stall release pc_o=0x4184, not 0x3400.
- eret_i=1, epc_i=0x3002 -> pc_o=0x3002, adel_o=1. Then jump to 0x7000 -> adel_o=1. Then jump to 0x6FFC -> adel_o=0.
- reset asserted while pend_o=1 -> next pc_o=0x3000, pend_o=0; the buffered target never appears.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the pipelined MIPS core front end.
// Redirect kinds are ordered so that a larger value means a higher priority.
package cpu_pkg;

  localparam int unsigned PC_WIDTH      = 32;
  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_ADDR   = 32'h0000_4180;
  localparam logic [31:0] PC_IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_IMEM_HI    = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_BR   = 2'd1,
    KIND_JMP  = 2'd2,
    KIND_ERET = 2'd3
  } redir_kind_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Fixed-priority redirect mux: eret > jump > branch.
// Exception entry is handled in pc_unit because it also flushes the pending buffer.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             eret_i,
  input  logic [WIDTH-1:0] epc_i,
  output logic [WIDTH-1:0] target_o,
  output redir_kind_e      kind_o
);

  always_comb begin
    target_o = '0;
    kind_o   = KIND_NONE;
    if (eret_i) begin
      target_o = epc_i;
      kind_o   = KIND_ERET;
    end else if (jump_i) begin
      target_o = jump_target_i;
      kind_o   = KIND_JMP;
    end else if (br_taken_i) begin
      target_o = br_target_i;
      kind_o   = KIND_BR;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with stall support and a one-entry redirect buffer for redirects seen while stalled.
//   state      | meaning
//   ST_RUN     | no redirect buffered; PC advances or is redirected unless stalled
//   ST_PENDING | redirect buffered in pend_tgt_q; applied on the first unstalled cycle
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH      = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = PC_RESET_ADDR,
  parameter logic [WIDTH-1:0] EXC_ADDR   = PC_EXC_ADDR,
  parameter logic [WIDTH-1:0] IMEM_LO    = PC_IMEM_LO,
  parameter logic [WIDTH-1:0] IMEM_HI    = PC_IMEM_HI
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             exc_req_i,
  input  logic             eret_i,
  input  logic [WIDTH-1:0] epc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc4_o,
  output logic             adel_o,
  output logic             pend_o
);

  // Power-up values keep outputs defined before the first reset edge.
  logic [WIDTH-1:0] pc_q       = RESET_ADDR;
  logic [WIDTH-1:0] pend_tgt_q = '0;
  redir_kind_e      pend_kind_q = KIND_NONE;
  pc_state_e        state_q    = ST_RUN;

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pend_tgt_d;
  redir_kind_e      pend_kind_d;
  pc_state_e        state_d;

  logic [WIDTH-1:0] sel_target;
  redir_kind_e      sel_kind;
  logic [WIDTH-1:0] pc_plus4;

  pc_next_sel #(.WIDTH(WIDTH)) u_next_sel (
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jump_i       (jump_i),
    .jump_target_i(jump_target_i),
    .eret_i       (eret_i),
    .epc_i        (epc_i),
    .target_o     (sel_target),
    .kind_o       (sel_kind)
  );

  assign pc_plus4 = pc_q + WIDTH'(4);

  always_comb begin
    pc_d        = pc_q;
    pend_tgt_d  = pend_tgt_q;
    pend_kind_d = pend_kind_q;
    state_d     = state_q;
    if (exc_req_i) begin
      pc_d        = EXC_ADDR;
      pend_tgt_d  = '0;
      pend_kind_d = KIND_NONE;
      state_d     = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!stall_i) begin
            pc_d = (sel_kind != KIND_NONE) ? sel_target : pc_plus4;
          end else if (sel_kind != KIND_NONE) begin
            pend_tgt_d  = sel_target;
            pend_kind_d = sel_kind;
            state_d     = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (stall_i) begin
            // Kind encoding is ordered by priority, so a plain compare decides overwrite.
            if (sel_kind > pend_kind_q) begin
              pend_tgt_d  = sel_target;
              pend_kind_d = sel_kind;
            end
          end else begin
            pc_d        = pend_tgt_q;
            pend_tgt_d  = '0;
            pend_kind_d = KIND_NONE;
            state_d     = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_ADDR;
      pend_tgt_q  <= '0;
      pend_kind_q <= KIND_NONE;
      state_q     <= ST_RUN;
    end else begin
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_kind_q <= pend_kind_d;
      state_q     <= state_d;
    end
  end

  assign pc_o   = pc_q;
  assign pc4_o  = pc_plus4;
  assign pend_o = (state_q == ST_PENDING);
  assign adel_o = (pc_q[1:0] != 2'b00) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus a randomized run against a behavioural model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = '0;
  logic        exc_req_i = 1'b0;
  logic        eret_i = 1'b0;
  logic [31:0] epc_i = '0;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        adel_o;
  logic        pend_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model: pending redirect kept as a priority rank (3 eret, 2 jump, 1 branch).
  logic [31:0] m_pc = 32'h0000_3000;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt = '0;
  int          m_rank = 0;

  pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jump_i       (jump_i),
    .jump_target_i(jump_target_i),
    .exc_req_i    (exc_req_i),
    .eret_i       (eret_i),
    .epc_i        (epc_i),
    .pc_o         (pc_o),
    .pc4_o        (pc4_o),
    .adel_o       (adel_o),
    .pend_o       (pend_o)
  );

  always #5 clk = ~clk;

  function automatic logic model_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  task automatic model_step();
    int          rank;
    logic [31:0] tgt;
    rank = 0;
    tgt  = '0;
    if (eret_i)          begin rank = 3; tgt = epc_i; end
    else if (jump_i)     begin rank = 2; tgt = jump_target_i; end
    else if (br_taken_i) begin rank = 1; tgt = br_target_i; end
    if (reset) begin
      m_pc = 32'h3000; m_pend = 0; m_rank = 0;
    end else if (exc_req_i) begin
      m_pc = 32'h4180; m_pend = 0; m_rank = 0;
    end else if (m_pend) begin
      if (!stall_i) begin
        m_pc = m_tgt; m_pend = 0; m_rank = 0;
      end else if (rank > m_rank) begin
        m_tgt = tgt; m_rank = rank;
      end
    end else if (!stall_i) begin
      m_pc = (rank != 0) ? tgt : m_pc + 32'd4;
    end else if (rank != 0) begin
      m_pend = 1; m_tgt = tgt; m_rank = rank;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    stall_i = 0; br_taken_i = 0; jump_i = 0; exc_req_i = 0; eret_i = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (pc_o !== 32'h3000) begin errors++; $display("FAIL prereset_pc got %h exp 00003000", pc_o); end
    reset = 1;
    tick();
    checks++;
    if (pc_o !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp 00003000", pc_o); end
    checks++;
    if (pend_o !== 1'b0 || adel_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags pend %b adel %b exp 0 0", pend_o, adel_o);
    end
    reset = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = exp_pc + 4;
      checks++;
      if (pc_o !== exp_pc || adel_o !== 1'b0 || pc4_o !== exp_pc + 4) begin
        errors++;
        $display("FAIL seq pc %h pc4 %h adel %b exp %h %h 0", pc_o, pc4_o, adel_o, exp_pc, exp_pc + 4);
      end
    end
  endtask

  task automatic test_priority();
    br_taken_i = 1; br_target_i = 32'h3100;
    jump_i = 1; jump_target_i = 32'h3200;
    tick();
    clear_inputs();
    checks++;
    if (pc_o !== 32'h3200) begin errors++; $display("FAIL prio_jump_over_br got %h exp 00003200", pc_o); end
  endtask

  task automatic test_stall_buffer();
    stall_i = 1; br_taken_i = 1; br_target_i = 32'h3400;
    tick();
    br_taken_i = 0;
    checks++;
    if (pc_o !== 32'h3200 || pend_o !== 1'b1) begin
      errors++; $display("FAIL stall1 pc %h pend %b exp 00003200 1", pc_o, pend_o);
    end
    tick();
    checks++;
    if (pc_o !== 32'h3200 || pend_o !== 1'b1) begin
      errors++; $display("FAIL stall2 pc %h pend %b exp 00003200 1", pc_o, pend_o);
    end
    stall_i = 0;
    tick();
    checks++;
    if (pc_o !== 32'h3400 || pend_o !== 1'b0) begin
      errors++; $display("FAIL release pc %h pend %b exp 00003400 0", pc_o, pend_o);
    end
    tick();
    checks++;
    if (pc_o !== 32'h3404) begin errors++; $display("FAIL after_release got %h exp 00003404", pc_o); end
  endtask

  task automatic test_exc_in_pending();
    stall_i = 1; br_taken_i = 1; br_target_i = 32'h3400;
    tick();
    br_taken_i = 0; exc_req_i = 1;
    tick();
    exc_req_i = 0;
    checks++;
    if (pc_o !== 32'h4180 || pend_o !== 1'b0) begin
      errors++; $display("FAIL exc_flush pc %h pend %b exp 00004180 0", pc_o, pend_o);
    end
    tick();
    checks++;
    if (pc_o !== 32'h4180) begin errors++; $display("FAIL exc_hold got %h exp 00004180", pc_o); end
    stall_i = 0;
    tick();
    checks++;
    if (pc_o !== 32'h4184) begin errors++; $display("FAIL exc_release got %h exp 00004184", pc_o); end
  endtask

  task automatic test_overwrite();
    stall_i = 1; br_taken_i = 1; br_target_i = 32'h3700;
    tick();
    br_taken_i = 0; jump_i = 1; jump_target_i = 32'h3800;
    tick();
    jump_i = 0; br_taken_i = 1; br_target_i = 32'h3900;
    tick();
    // Release with a fresh branch asserted: the buffered jump must win.
    stall_i = 0; br_target_i = 32'h3A00;
    tick();
    clear_inputs();
    checks++;
    if (pc_o !== 32'h3800) begin errors++; $display("FAIL overwrite_jump got %h exp 00003800", pc_o); end
    stall_i = 1; jump_i = 1; jump_target_i = 32'h3B00;
    tick();
    jump_i = 0; eret_i = 1; epc_i = 32'h3C00;
    tick();
    eret_i = 0; stall_i = 0;
    tick();
    checks++;
    if (pc_o !== 32'h3C00) begin errors++; $display("FAIL overwrite_eret got %h exp 00003C00", pc_o); end
  endtask

  task automatic test_adel();
    eret_i = 1; epc_i = 32'h3002; jump_i = 1; jump_target_i = 32'h3300;
    tick();
    clear_inputs();
    checks++;
    if (pc_o !== 32'h3002 || adel_o !== 1'b1) begin
      errors++; $display("FAIL adel_misalign pc %h adel %b exp 00003002 1", pc_o, adel_o);
    end
    jump_i = 1; jump_target_i = 32'h7000;
    tick();
    checks++;
    if (pc_o !== 32'h7000 || adel_o !== 1'b1) begin
      errors++; $display("FAIL adel_above pc %h adel %b exp 00007000 1", pc_o, adel_o);
    end
    jump_target_i = 32'h6FFC;
    tick();
    checks++;
    if (pc_o !== 32'h6FFC || adel_o !== 1'b0) begin
      errors++; $display("FAIL adel_top pc %h adel %b exp 00006FFC 0", pc_o, adel_o);
    end
    jump_target_i = 32'h2FFC;
    tick();
    checks++;
    if (adel_o !== 1'b1) begin errors++; $display("FAIL adel_below got %b exp 1", adel_o); end
    jump_target_i = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    checks++;
    if (pc4_o !== 32'h0) begin errors++; $display("FAIL pc4_wrap got %h exp 00000000", pc4_o); end
  endtask

  task automatic test_reset_pending();
    stall_i = 1; br_taken_i = 1; br_target_i = 32'h3600;
    tick();
    clear_inputs();
    checks++;
    if (pend_o !== 1'b1) begin errors++; $display("FAIL rstpend_setup got %b exp 1", pend_o); end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (pc_o !== 32'h3000 || pend_o !== 1'b0) begin
      errors++; $display("FAIL rstpend pc %h pend %b exp 00003000 0", pc_o, pend_o);
    end
    tick();
    checks++;
    if (pc_o !== 32'h3004) begin errors++; $display("FAIL rstpend_discard got %h exp 00003004", pc_o); end
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 9) == 0) return $urandom();
    return 32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
  endfunction

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      reset         = ($urandom_range(0, 59) == 0);
      exc_req_i     = ($urandom_range(0, 24) == 0);
      stall_i       = ($urandom_range(0, 1) == 1);
      eret_i        = ($urandom_range(0, 7) == 0);
      jump_i        = ($urandom_range(0, 4) == 0);
      br_taken_i    = ($urandom_range(0, 3) == 0);
      epc_i         = rand_target();
      jump_target_i = rand_target();
      br_target_i   = rand_target();
      tick();
      checks++;
      if (pc_o !== m_pc || pend_o !== m_pend || pc4_o !== m_pc + 32'd4 || adel_o !== model_adel(m_pc)) begin
        errors++;
        $display("FAIL rand[%0d] pc %h pend %b pc4 %h adel %b exp %h %b %h %b", i, pc_o, pend_o, pc4_o,
                 adel_o, m_pc, m_pend, m_pc + 32'd4, model_adel(m_pc));
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_priority();
    test_stall_buffer();
    test_exc_in_pending();
    test_overwrite();
    test_adel();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
